// File: rtl/tim_pkg.sv
// Shared types and defaults for the timer input-capture block.
package tim_pkg;

    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } tim_cap_state_t;

endpackage

// File: rtl/tim_edge_sync.sv
// Synchronises an asynchronous input and flags its rising and falling edges.
// Latency: 2 flops to sync, edges combinational from the synchronised and delayed samples.
// Backpressure: none; clr holds the whole chain at 0.
module tim_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
        end else if (clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    assign rise = sync2 & ~dly;
    assign fall = ~sync2 & dly;

endmodule

// File: rtl/tim_capture.sv
// Measures period and high time of pwm_in in prescaled ticks; publishes CCR1/CCR2 as a pair.
// Latency: results register on the clk edge after the synchronised closing rise is seen.
// Backpressure: none; each new period overwrites CCR1/CCR2, capture_valid is a bare pulse.
module tim_capture
    import tim_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] TIM_PSC,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] TIM_CCR1,
    output logic [CNT_W-1:0] TIM_CCR2,
    output logic             capture_valid,
    output logic             capture_overflow
);

    tim_cap_state_t   state;
    tim_cap_state_t   state_nxt;
    logic             rise;
    logic             fall;
    logic             tick;
    logic             sat;
    logic             cap_evt;
    logic             high_evt;
    logic [CNT_W-1:0] psc_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_cap;
    logic [CNT_W-1:0] high_q;

    tim_edge_sync u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~en),
        .din   (pwm_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign tick    = (psc_cnt == TIM_PSC);
    assign cnt_cap = cnt + CNT_W'(tick);

    // Saturation beats any edge in the same cycle: the count would already have wrapped.
    assign sat      = en && (state == HIGH || state == LOW) && tick && (cnt == {CNT_W{1'b1}});
    assign cap_evt  = en && (state == LOW)  && rise && !sat;
    assign high_evt = en && (state == HIGH) && fall && !sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt <= '0;
        end else if (!en || rise || tick) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || rise) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = ARM;
                ARM:  if (rise) state_nxt = HIGH;
                HIGH: begin
                    if (sat)       state_nxt = ARM;
                    else if (fall) state_nxt = LOW;
                end
                LOW: begin
                    if (sat)       state_nxt = ARM;
                    else if (rise) state_nxt = HIGH;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_q           <= '0;
            TIM_CCR1         <= '0;
            TIM_CCR2         <= '0;
            capture_valid    <= 1'b0;
            capture_overflow <= 1'b0;
        end else begin
            capture_valid    <= cap_evt;
            capture_overflow <= sat;
            if (high_evt) begin
                high_q <= cnt_cap;
            end
            if (cap_evt) begin
                TIM_CCR1 <= cnt_cap;
                TIM_CCR2 <= high_q;
            end
        end
    end

endmodule

// File: tb/tb_tim_capture.sv
// Scoreboarded bench for tim_capture: expected CCR pairs are queued ahead of each closing rise
// and popped whenever capture_valid pulses.
module tb_tim_capture;
    import tim_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] TIM_PSC;
    logic        pwm_in;
    logic [15:0] TIM_CCR1;
    logic [15:0] TIM_CCR2;
    logic        capture_valid;
    logic        capture_overflow;

    typedef struct {
        logic [15:0] per;
        logic [15:0] hi;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_valid = 0;
    int   n_ovf = 0;
    int   cyc = 0;
    int   ovf_cyc = 0;
    int   last_valid_cyc = 0;
    int   prev_valid_cyc = 0;

    always #5 clk = ~clk;

    tim_capture #(.CNT_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .TIM_PSC          (TIM_PSC),
        .pwm_in           (pwm_in),
        .TIM_CCR1         (TIM_CCR1),
        .TIM_CCR2         (TIM_CCR2),
        .capture_valid    (capture_valid),
        .capture_overflow (capture_overflow)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (capture_overflow === 1'b1) begin
            n_ovf   = n_ovf + 1;
            ovf_cyc = cyc;
        end
        if (capture_valid === 1'b1) begin
            n_valid        = n_valid + 1;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            n_cmp          = n_cmp + 1;
            if (q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL sb_unexpected_valid: ccr1=%0d ccr2=%0d, required no capture", TIM_CCR1, TIM_CCR2);
            end else begin
                mon_e = q.pop_front();
                if (TIM_CCR1 !== mon_e.per || TIM_CCR2 !== mon_e.hi) begin
                    n_err = n_err + 1;
                    $display("FAIL sb_ccr: got ccr1=%0d ccr2=%0d, required ccr1=%0d ccr2=%0d",
                             TIM_CCR1, TIM_CCR2, mon_e.per, mon_e.hi);
                end
            end
        end
    end

    // Starts and ends 1 time unit after a rising clk edge.
    task automatic drive_cycle(input int hi, input int lo);
        pwm_in = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int per, input int hi);
        exp_t e;
        e.per = 16'(per);
        e.hi  = 16'(hi);
        q.push_back(e);
    endtask

    task automatic rearm();
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        en      = 1'b0;
        TIM_PSC = 16'd0;
        pwm_in  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp = n_cmp + 4;
        if (TIM_CCR1 !== 16'd0) begin n_err++; $display("FAIL reset_ccr1: got %0d, required 0", TIM_CCR1); end
        if (TIM_CCR2 !== 16'd0) begin n_err++; $display("FAIL reset_ccr2: got %0d, required 0", TIM_CCR2); end
        if (capture_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", capture_valid); end
        if (capture_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b, required 0", capture_overflow); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int v0;
        v0 = n_valid;
        drive_cycle(30, 70);
        for (int i = 0; i < 4; i++) begin
            push_exp(100, 30);
            drive_cycle(30, 70);
        end
        n_cmp = n_cmp + 3;
        if (n_valid - v0 !== 4) begin n_err++; $display("FAIL basic_count: got %0d captures, required 4", n_valid - v0); end
        if (last_valid_cyc - prev_valid_cyc !== 100) begin
            n_err++; $display("FAIL basic_gap: got %0d cycles, required 100", last_valid_cyc - prev_valid_cyc);
        end
        if (q.size() !== 0) begin n_err++; $display("FAIL basic_drain: got %0d pending, required 0", q.size()); end
    endtask

    task automatic test_prescaler();
        int v0;
        TIM_PSC = 16'd3;
        rearm();
        v0 = n_valid;
        drive_cycle(40, 60);
        n_cmp = n_cmp + 1;
        if (n_valid !== v0) begin n_err++; $display("FAIL psc_first_rise: got %0d captures, required 0", n_valid - v0); end
        for (int i = 0; i < 2; i++) begin
            push_exp(25, 10);
            drive_cycle(40, 60);
        end
        n_cmp = n_cmp + 1;
        if (n_valid - v0 !== 2) begin n_err++; $display("FAIL psc_count: got %0d captures, required 2", n_valid - v0); end
    endtask

    task automatic test_overflow();
        int o0;
        int v0;
        int c0;
        int delta;
        TIM_PSC = 16'd0;
        rearm();
        o0 = n_ovf;
        v0 = n_valid;
        c0 = cyc;
        pwm_in = 1'b1;
        for (int i = 0; i < 70000 && n_ovf == o0; i++) @(posedge clk);
        #1;
        delta = ovf_cyc - c0;
        n_cmp = n_cmp + 2;
        if (n_ovf !== o0 + 1) begin n_err++; $display("FAIL ovf_pulse: got %0d pulses, required 1", n_ovf - o0); end
        if (delta < 65536 || delta > 65540) begin
            n_err++; $display("FAIL ovf_time: got %0d cycles after input rise, required 65536..65540", delta);
        end
        repeat (200) @(posedge clk);
        #1;
        n_cmp = n_cmp + 5;
        if (n_ovf !== o0 + 1) begin n_err++; $display("FAIL ovf_once: got %0d pulses, required 1", n_ovf - o0); end
        if (n_valid !== v0) begin n_err++; $display("FAIL ovf_no_capture: got %0d captures, required 0", n_valid - v0); end
        if (TIM_CCR1 !== 16'd25) begin n_err++; $display("FAIL ovf_ccr1_hold: got %0d, required 25", TIM_CCR1); end
        if (TIM_CCR2 !== 16'd10) begin n_err++; $display("FAIL ovf_ccr2_hold: got %0d, required 10", TIM_CCR2); end
        if (dut.state !== ARM) begin n_err++; $display("FAIL ovf_state: got %0d, required %0d", dut.state, ARM); end
    endtask

    task automatic test_en_drop();
        int v0;
        pwm_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        pwm_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        v0 = n_valid;
        drive_cycle(30, 70);
        n_cmp = n_cmp + 3;
        if (n_valid !== v0) begin n_err++; $display("FAIL en_first_rise: got %0d captures, required 0", n_valid - v0); end
        if (TIM_CCR1 !== 16'd25) begin n_err++; $display("FAIL en_ccr1_hold: got %0d, required 25", TIM_CCR1); end
        if (TIM_CCR2 !== 16'd10) begin n_err++; $display("FAIL en_ccr2_hold: got %0d, required 10", TIM_CCR2); end
        push_exp(100, 30);
        drive_cycle(30, 70);
        n_cmp = n_cmp + 1;
        if (n_valid !== v0 + 1) begin n_err++; $display("FAIL en_second_rise: got %0d captures, required 1", n_valid - v0); end
    endtask

    task automatic test_reset_mid();
        int v0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp = n_cmp + 4;
        if (TIM_CCR1 !== 16'd0) begin n_err++; $display("FAIL rst_mid_ccr1: got %0d, required 0", TIM_CCR1); end
        if (TIM_CCR2 !== 16'd0) begin n_err++; $display("FAIL rst_mid_ccr2: got %0d, required 0", TIM_CCR2); end
        if (capture_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b, required 0", capture_valid); end
        if (capture_overflow !== 1'b0) begin n_err++; $display("FAIL rst_mid_ovf: got %b, required 0", capture_overflow); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        v0 = n_valid;
        repeat (50) @(posedge clk);
        #1;
        n_cmp = n_cmp + 1;
        if (n_valid !== v0) begin n_err++; $display("FAIL rst_mid_stale: got %0d captures, required 0", n_valid - v0); end
        drive_cycle(30, 70);
        n_cmp = n_cmp + 1;
        if (n_valid !== v0) begin n_err++; $display("FAIL rst_mid_first_rise: got %0d captures, required 0", n_valid - v0); end
        push_exp(100, 30);
        drive_cycle(30, 70);
        n_cmp = n_cmp + 1;
        if (n_valid !== v0 + 1) begin n_err++; $display("FAIL rst_mid_recover: got %0d captures, required 1", n_valid - v0); end
    endtask

    task automatic test_glitch();
        logic xbad;
        xbad = 1'b0;
        rearm();
        pwm_in = 1'b1;
        @(posedge clk);
        #1;
        pwm_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if ($isunknown({TIM_CCR1, TIM_CCR2, capture_valid, capture_overflow})) xbad = 1'b1;
            if (i == 10) begin
                n_cmp = n_cmp + 1;
                if (dut.state !== LOW) begin n_err++; $display("FAIL glitch_state: got %0d, required %0d", dut.state, LOW); end
            end
        end
        push_exp(41, 1);
        drive_cycle(30, 70);
        push_exp(100, 30);
        drive_cycle(30, 70);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if ($isunknown({TIM_CCR1, TIM_CCR2, capture_valid, capture_overflow})) xbad = 1'b1;
        end
        n_cmp = n_cmp + 2;
        if (xbad !== 1'b0) begin n_err++; $display("FAIL glitch_x: got X on an output, required none"); end
        if (q.size() !== 0) begin n_err++; $display("FAIL glitch_drain: got %0d pending, required 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescaler();
        test_overflow();
        test_en_drop();
        test_reset_mid();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tim_capture.md
# tim_capture

Input-capture companion to the timer's PWM channels: measures the period and high time of an external PWM-style input. A prescaler generates count ticks from `clk`, a 16-bit counter measures edge-to-edge intervals, and each complete period is published as a coherent pair in `TIM_CCR1` (period) and `TIM_CCR2` (high time). It sits beside the timer in the peripheral block, and its results are read by the core over the same register map.

## Interface
Parameters:
- `CNT_W`, 16, width of prescaler, counter and capture registers.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  capture enable; low forces IDLE.
- `TIM_PSC`  in  CNT_W  prescaler; one tick every `TIM_PSC+1` clk cycles.
- `pwm_in`  in  1  asynchronous input signal.
- `TIM_CCR1`  out  CNT_W  last measured period, in ticks.
- `TIM_CCR2`  out  CNT_W  last measured high time, in ticks.
- `capture_valid`  out  1  one-cycle pulse when CCR1/CCR2 update.
- `capture_overflow`  out  1  one-cycle pulse on counter saturation.

## Operation
- `pwm_in` passes through a 2-flop synchronizer plus one delay flop. Rise = sync high and delay low; fall = sync low and delay high.
- Prescaler `psc_cnt`:
  - Increments every clk.
  - `tick` = (`psc_cnt == TIM_PSC`), after which `psc_cnt` wraps to 0.
  - A rise clears `psc_cnt` to 0.
- Counter `cnt`:
  - +1 on each tick.
  - A rise loads `cnt` to 0; the rise wins over a simultaneous tick.
  - Every captured value is `cnt + tick`, the count including the current cycle's tick.
- State machine:
  - IDLE: when `en` is low, stay here and hold `cnt`, `psc_cnt` and the edge flops at 0. When `en` is high, go to ARM.
  - ARM: ignore falls. On a rise, clear the counters and go to HIGH. No capture is made on the first rise.
  - HIGH: on a fall, latch `cnt+tick` into internal `high_q` and go to LOW.
  - LOW: on a rise, set `TIM_CCR1 <= cnt+tick` and `TIM_CCR2 <= high_q`, pulse `capture_valid`, clear the counters and go to HIGH.
- Saturation: in HIGH or LOW, a tick with `cnt == 2^CNT_W-1` pulses `capture_overflow` and moves to ARM. CCR1/CCR2 are left unchanged. This covers duty 0%, duty 100% and a stalled input.
- `en` falling in any state moves to IDLE on the next clk. CCR1/CCR2 hold their last values.

## Timing
- Reset values: `TIM_CCR1`=0, `TIM_CCR2`=0, `capture_valid`=0, `capture_overflow`=0, state IDLE, all counters 0.
- Edge latency: a `pwm_in` change sampled at clk edge k is detected during cycle k+2. Outputs update at edge k+3.
- `capture_valid` is high for exactly one cycle and always coincides with a CCR update. CCR1 and CCR2 never update separately.
- With `TIM_PSC`=0, a period of P clk cycles captures `TIM_CCR1`=P.
- `TIM_PSC` changes take effect on the next prescaler compare. No glitch handling is required.
- Pulses shorter than 2 clk cycles may be lost; this is accepted.
- Reset asserted mid-measurement clears everything immediately (asynchronously). Measurement restarts from ARM after `rst_n` rises with `en` high.

## Structure
- `tim_pkg` holds:
  - `CNT_W` default constant.
  - `tim_cap_state_t` enum: `IDLE`, `ARM`, `HIGH`, `LOW`.
- Sub-module `tim_edge_sync`:
  - 2-flop synchronizer plus delay flop.
  - Outputs `rise` and `fall`.
  - Clocked by `clk`, reset by `rst_n`.
  - Reused by future external-trigger inputs.
- Top module: prescaler, counter, FSM and capture registers.

## Test plan
- `TIM_PSC`=0, `en`=1, `pwm_in` high 30 / low 70 clk, repeated → from the second rise onward, `capture_valid` pulses every 100 clk with `TIM_CCR1`=100 and `TIM_CCR2`=30.
- `TIM_PSC`=3, high 40 / period 100 clk → `TIM_CCR1`=25, `TIM_CCR2`=10. The first rise after `en` produces no `capture_valid`.
- `pwm_in` held high after a rise, `TIM_PSC`=0 → `capture_overflow` pulses once 65536 cycles later and state returns to ARM. CCR values are unchanged.
- `en` dropped mid-high phase, then restored → no capture, CCRs hold. The next valid capture occurs only after two further rises.
- `rst_n` pulsed low mid-LOW phase → all outputs are 0 immediately, and no stale `capture_valid` appears after release.
- 1-cycle glitch on `pwm_in` while the input is otherwise low → no more than one spurious rise/fall pair. The FSM state stays consistent, and the bench checks that no X appears on any output.
